stack_ptr_ctrl: RTL
===================

// Module: stack_ptr_ctrl
// PURPOSE
//  Hardware stack controller for the stack machine: owns the 14-bit stack pointer (SP), turns push/pop
//  commands into synchronous-RAM accesses, and returns popped data with a valid strobe.
//  Push is the increment direction: write at SP, then SP+1. Pop is the decrement direction: SP-1, then read.
//  Sits between the datapath control unit and the single-port stack RAM.
// PARAMETERS
//  AW  14  SP / RAM address width; capacity = 2**AW-1 entries
//  DW  16  data word width
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  cmd_valid    in   1   command request
//  cmd_op       in   1   1=push, 0=pop
//  cmd_wdata    in   DW  push data
//  cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
//  resp_valid   out  1   one-cycle strobe: resp_rdata holds popped word
//  resp_rdata   out  DW  popped word (registered)
//  mem_addr     out  AW  RAM address (combinational)
//  mem_we       out  1   RAM write enable
//  mem_wdata    out  DW  RAM write data
//  mem_rdata    in   DW  RAM read data, valid 1 cycle after address
//  sp           out  AW  current stack pointer (entry count)
//  empty, full  out  1   sp==0 / sp==2**AW-1
//  err          out  1   illegal op indication (see CONFIGURATION)
//  err_clr      in   1   clears sticky error (macro builds only)
// BEHAVIOUR
//  Reset: sp=0, state=IDLE, cmd_ready=1, resp_valid=0, resp_rdata=0, mem_we=0, err=0, empty=1, full=0.
//  FSM: IDLE -> RD_WAIT -> RESP -> IDLE. cmd_ready=1 only in IDLE, and only when the error lock is clear.
//  Push accepted (not full): same cycle mem_addr=sp, mem_we=1, mem_wdata=cmd_wdata; sp<=sp+1; stay IDLE.
//    Back-to-back pushes run one per cycle.
//  Pop accepted (not empty): same cycle mem_addr=sp-1, mem_we=0; sp<=sp-1; ->RD_WAIT.
//    RD_WAIT: resp_rdata<=mem_rdata; ->RESP.
//    RESP: resp_valid=1 for exactly one cycle; ->IDLE.
//    Pop latency: accept at cycle T, resp_valid at T+2. Pop throughput is one per 3 cycles.
//  Arithmetic: SP+1 and SP-1 are modulo 2**AW. Full/empty guards mean SP never wraps.
//  Illegal ops (push when full, pop when empty): no RAM access, sp unchanged, no state change.
//  Idle cycles: mem_we=0, mem_addr=sp.
//  Reset asserted mid-pop (RD_WAIT/RESP): immediate return to reset values; no resp_valid emitted.
// CONFIGURATION
//  STACK_ERR_LOCK_EN defined:
//    - Illegal op sets sticky err=1; cmd_ready is held 0 until err_clr is sampled high.
//    - err_clr clears err the next cycle; sp is retained.
//  STACK_ERR_LOCK_EN undefined:
//    - Illegal op is dropped with a one-cycle err pulse; cmd_ready is unaffected.
//    - err_clr is ignored.
// STRUCTURE
//  Package stack_pkg: AW/DW defaults, OP_PUSH=1'b1 / OP_POP=1'b0, state enum {IDLE,RD_WAIT,RESP}.
//  Sub-module inc_dec14b: combinational ripple incrementer/decrementer with input dir, output sp_next.
//    It computes the SP update; stack_ptr_ctrl holds all sequential logic.
// TESTING
//  Bench models a 1-cycle synchronous RAM.
//  1. Reset: rst_n=0 mid-cycle -> sp=0, empty=1, cmd_ready=1, resp_valid=0 without waiting for a clock edge.
//  2. Push 0x0A11, 0x0B22, 0x0C33 back-to-back -> mem_we on 3 consecutive cycles at addr 0,1,2; sp=3.
//  3. Three pops after test 2 -> resp_rdata 0x0C33, 0x0B22, 0x0A11, each 2 cycles after accept.
//     Reads at addr 2,1,0; sp=0; empty=1.
//  4. Pop on empty -> mem_we=0, sp=0, err per build.
//     Lock build: err stays 1 and cmd_ready=0 until err_clr.
//  5. AW=3: push 7 words -> full=1. 8th push -> dropped, sp=7, no write, err asserted.
//  6. Pop accepted, rst_n pulsed low during RD_WAIT -> no resp_valid, sp=0, next push writes addr 0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the stack controller: default widths, push/pop opcodes,
// and the pop-sequence FSM states.
package stack_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 16;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/stack_ptr_ctrl_inc_dec14b.sv
// Ripple incrementer/decrementer for the stack pointer (modulo 2**W).
// Ports: sp (current), dir (1=+1, 0=-1), sp_next (result).
module inc_dec14b
  import stack_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0] sp,
  input  logic         dir,
  output logic [W-1:0] sp_next
);

  // c[i] is the carry (increment) or borrow (decrement) into bit i.
  // Carry ripples through ones; borrow ripples through zeros.
  logic [W-1:0] c;

  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < W - 1; i++) begin
      c[i+1] = c[i] & ((dir == OP_PUSH) ? sp[i] : ~sp[i]);
    end
  end

  assign sp_next = sp ^ c;

endmodule

// File: rtl/stack_ptr_ctrl.sv
// Stack controller: owns SP, maps push/pop onto a 1-cycle sync RAM and
// returns popped words with a resp_valid strobe.
// Ports: cmd_valid/cmd_op/cmd_wdata/cmd_ready (command), resp_valid/
// resp_rdata (pop result), mem_addr/mem_we/mem_wdata/mem_rdata (RAM),
// sp/empty/full (status), err/err_clr (illegal-op reporting).
// Build option: STACK_ERR_LOCK_EN makes err sticky and blocks commands
// until err_clr; otherwise err is a one-cycle pulse and err_clr is unused.
module stack_ptr_ctrl
  import stack_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic          cmd_op,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_ready,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] sp,
  output logic          empty,
  output logic          full,
  output logic          err,
  input  logic          err_clr
);

  state_e        state_q, state_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] sp_step;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          err_q, err_d;

  logic lock;
  logic accept;
  logic push_ok;
  logic pop_ok;
  logic illegal;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == '1);

`ifdef STACK_ERR_LOCK_EN
  assign lock = err_q;
`else
  assign lock = 1'b0;
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
`endif

  assign cmd_ready = (state_q == IDLE) && !lock;
  assign accept    = cmd_valid && cmd_ready;
  assign push_ok   = accept && (cmd_op == OP_PUSH) && !full;
  assign pop_ok    = accept && (cmd_op == OP_POP) && !empty;
  // Handshake completes but the op is dropped.
  assign illegal   = accept && !push_ok && !pop_ok;

  // Direction follows the opcode: sp+1 for push, sp-1 for pop.
  inc_dec14b #(
    .W(AW)
  ) u_step (
    .sp     (sp_q),
    .dir    (cmd_op),
    .sp_next(sp_step)
  );

  // Pop reads below SP, so the decremented value is the read address.
  assign mem_we    = push_ok;
  assign mem_wdata = cmd_wdata;
  assign mem_addr  = pop_ok ? sp_step : sp_q;

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (push_ok) begin
          sp_d = sp_step;
        end
        if (pop_ok) begin
          sp_d    = sp_step;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        resp_rdata_d = mem_rdata;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
`ifdef STACK_ERR_LOCK_EN
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end else if (illegal) begin
      err_d = 1'b1;
    end
`else
    err_d = illegal;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sp_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      err_q        <= err_d;
    end
  end

  assign sp         = sp_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign err        = err_q;

endmodule
